ddram_rom_bridge: RTL and testbench
===================================

Name: ddram_rom_bridge

Overview:
- Responder end of the toggle req/ack ROM handshake.
- Accepts 16-bit ROM download writes and 64-bit core ROM fetch reads, and executes each as a single-beat access on the MiSTer DDRAM Avalon-style port.
- Sits between the download/ROM-fetch logic and DDRAM_*; all on one clock, so any CDC is done by the requester.

Parameters:
- BASE_ADDR, 29'h06000000, 64-bit-word DDRAM address of ROM byte 0.
- AW, 25, byte-address width of wraddr/rdaddr.

Ports:
- DDRAM_CLK  in  1  sole clock.
- RESET_N  in  1  synchronous, active-low reset.
- wraddr  in  AW  write byte address; bit 0 ignored.
- din  in  16  write data, byte-swapped by requester.
- we_req  in  1  write request toggle.
- we_ack  out  1  write acknowledge toggle.
- rdaddr  in  AW  read byte address; bits[2:0] ignored.
- rd_req  in  1  read request toggle.
- rd_ack  out  1  read acknowledge toggle.
- dout  out  64  read data, valid when rd_ack==rd_req.
- DDRAM_BUSY  in  1  waitrequest.
- DDRAM_BURSTCNT  out  8  constant 1.
- DDRAM_ADDR  out  29  word address.
- DDRAM_DOUT  in  64  read beat.
- DDRAM_DOUT_READY  in  1  read beat valid.
- DDRAM_RD  out  1  read command.
- DDRAM_DIN  out  64  write data.
- DDRAM_BE  out  8  byte enables.
- DDRAM_WE  out  1  write command.

Behaviour:
- Reset while RESET_N=0 at the clock edge:
  - we_ack=0, rd_ack=0, dout=0, RD=WE=0, ADDR=0, DIN=0, BE=0, BURSTCNT=1.
  - State to IDLE; cache invalid; any in-flight transaction is abandoned.
- Pending conditions: write pending = we_req!=we_ack; read pending = rd_req!=rd_ack.
- IDLE, write pending (write wins over read):
  - ADDR = BASE_ADDR + wraddr[AW-1:3]; DIN = {4{din}}.
  - BE = 8'b11 << (2*wraddr[2:1]).
  - WE=1; go to WR.
- IDLE, read pending:
  - Cache hit: dout=cache line, toggle rd_ack next edge; stay IDLE.
  - Miss: ADDR = BASE_ADDR + rdaddr[AW-1:3]; RD=1; go to RD_CMD.
- WR: hold WE, ADDR, DIN and BE while DDRAM_BUSY=1. At the first edge with BUSY=0: WE=0, toggle we_ack, go to IDLE.
- RD_CMD: hold RD while BUSY=1. At the first edge with BUSY=0: RD=0, go to RD_WAIT.
- RD_WAIT: on DOUT_READY, dout=DDRAM_DOUT, fill cache (tag=rdaddr[AW-1:3]), toggle rd_ack, go to IDLE.
- Minimum latency:
  - Write ack: 2 edges after the request toggle (BUSY=0).
  - Read hit: 1 edge.
  - Read miss: 2 edges plus DDR latency.
- The bridge never issues a new command before the previous read beat returns (one outstanding access).
- A write whose line matches the cache tag invalidates the cache at WR entry.
- DOUT_READY seen in IDLE/WR/RD_CMD (a stale beat after reset) is ignored. After reset, the next RD is not issued until any stale beat is drained or 64 idle cycles have passed (drain counter).
- Simultaneous read/write pending: the write is served first, then the read, which is re-evaluated against the cache.
- Requesters must hold address/data stable while a request is pending. A re-toggle while pending is a protocol error: the block keeps servicing the original request.

Optional Feature:
- Macro: DDRAM_ROM_RDCACHE_EN.
- With the macro: single-line 64-bit read cache as described above.
- Without it: no cache registers; every read misses; write invalidation logic is absent; timing otherwise identical.

Decomposition:
- Package ddram_rom_bridge_pkg holds:
  - state enum {IDLE, WR, RD_CMD, RD_WAIT};
  - BASE_ADDR default;
  - DRAIN_CYCLES=64;
  - the BE-from-halfword-index function.
- One natural sub-module: ddram_rom_line_cache (tag, valid, data, hit, fill, invalidate), instantiated only under DDRAM_ROM_RDCACHE_EN.

Test Plan:
- Download write:
  - Stimulus: wraddr=25'h000006, din=16'hA55A, toggle we_req, BUSY=0.
  - Required: WE pulse 1 cycle, ADDR=29'h06000000, BE=8'hC0, DIN=64'hA55AA55AA55AA55A; we_ack toggles 2 edges after the request.
- Busy stall:
  - Stimulus: same write with BUSY=1 for 5 cycles.
  - Required: WE/ADDR/BE held for 6 cycles; single acceptance; one we_ack toggle.
- Read miss then hit:
  - Stimulus: rdaddr=25'h000100, DOUT=64'h0123456789ABCDEF after 7 cycles.
  - Required: RD at ADDR=29'h06000020; dout matches; rd_ack toggles.
  - Stimulus: re-request the same line.
  - Required: rd_ack in 1 edge, no RD issued (cache build only).
- Write invalidates:
  - Stimulus: after a cached read of 25'h000100, write 25'h000102, then read 25'h000100.
  - Required: the read issues DDRAM_RD.
- Simultaneous requests:
  - Stimulus: toggle we_req and rd_req on the same edge.
  - Required: WE precedes RD; we_ack toggles before rd_ack.
- Reset mid-read:
  - Stimulus: assert RESET_N=0 in RD_WAIT; release; a stale DOUT_READY arrives; then a new read.
  - Required: all outputs 0 during reset; the stale beat does not change dout or rd_ack; the new read completes with its own data.

Source files
------------

// File: rtl/ddram_rom_bridge_pkg.sv
// ddram_rom_bridge_pkg: FSM states, DDRAM defaults and the halfword byte-enable helper
package ddram_rom_bridge_pkg;
  typedef enum logic [1:0] {IDLE, WR, RD_CMD, RD_WAIT} state_t;
  localparam logic [28:0] BASE_ADDR_DEFAULT = 29'h06000000;
  localparam int DRAIN_CYCLES = 64;
  function automatic logic [7:0] hw_be(input logic [1:0] hw);
    return 8'b11 << {hw, 1'b0};
  endfunction
endpackage

// File: rtl/ddram_rom_line_cache.sv
// ddram_rom_line_cache: single 64-bit line read cache with tag match, fill and same-line invalidation
module ddram_rom_line_cache import ddram_rom_bridge_pkg::*; #(
  parameter int TW = 22
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [TW-1:0] lookup_tag,
  output logic          hit,
  output logic [63:0]   line_data,
  input  logic          fill,
  input  logic [TW-1:0] fill_tag,
  input  logic [63:0]   fill_data,
  input  logic          inval,
  input  logic [TW-1:0] inval_tag
);
  logic          valid;
  logic [TW-1:0] tag;
  assign hit = valid && lookup_tag == tag;
  // line validity: set by a returned beat, cleared by a write into the cached line
  always_ff @(posedge clk)
    if (!reset_n) valid <= 1'b0;
    else if (fill) valid <= 1'b1;
    else if (inval && inval_tag == tag) valid <= 1'b0;
  // tag and data are only meaningful while valid, so they need no reset
  always_ff @(posedge clk)
    if (fill) begin
      tag       <= fill_tag;
      line_data <= fill_data;
    end
endmodule

// File: rtl/ddram_rom_bridge.sv
// ddram_rom_bridge: toggle req/ack ROM write/fetch responder on the DDRAM port; read cache under DDRAM_ROM_RDCACHE_EN
module ddram_rom_bridge import ddram_rom_bridge_pkg::*; #(
  parameter logic [28:0] BASE_ADDR = BASE_ADDR_DEFAULT,
  parameter int          AW        = 25
) (
  input  logic          DDRAM_CLK,
  input  logic          RESET_N,
  input  logic [AW-1:0] wraddr,
  input  logic [15:0]   din,
  input  logic          we_req,
  output logic          we_ack,
  input  logic [AW-1:0] rdaddr,
  input  logic          rd_req,
  output logic          rd_ack,
  output logic [63:0]   dout,
  input  logic          DDRAM_BUSY,
  output logic [7:0]    DDRAM_BURSTCNT,
  output logic [28:0]   DDRAM_ADDR,
  input  logic [63:0]   DDRAM_DOUT,
  input  logic          DDRAM_DOUT_READY,
  output logic          DDRAM_RD,
  output logic [63:0]   DDRAM_DIN,
  output logic [7:0]    DDRAM_BE,
  output logic          DDRAM_WE
);
  state_t      state, state_n;
  logic        wr_pend, rd_pend, hit, start_wr, start_rd, take_hit, rd_done;
  logic [6:0]  drain_cnt;
  logic [63:0] line_data;
  logic        unused_bits;
  assign wr_pend        = we_req ^ we_ack;
  assign rd_pend        = rd_req ^ rd_ack;
  assign DDRAM_BURSTCNT = 8'd1;
  assign unused_bits    = ^{wraddr[0], rdaddr[2:0]};
`ifdef DDRAM_ROM_RDCACHE_EN
  ddram_rom_line_cache #(.TW(AW - 3)) u_cache (
    .clk        (DDRAM_CLK),
    .reset_n    (RESET_N),
    .lookup_tag (rdaddr[AW-1:3]),
    .hit        (hit),
    .line_data  (line_data),
    .fill       (rd_done),
    .fill_tag   (rdaddr[AW-1:3]),
    .fill_data  (DDRAM_DOUT),
    .inval      (start_wr),
    .inval_tag  (wraddr[AW-1:3])
  );
`else
  assign hit       = 1'b0;
  assign line_data = '0;
`endif
  // state register; reset abandons any in-flight access
  always_ff @(posedge DDRAM_CLK)
    state <= RESET_N ? state_n : IDLE;
  // next state and command strobes; writes win, misses wait for the post-reset drain
  always_comb begin
    state_n  = state;
    start_wr = 1'b0;
    start_rd = 1'b0;
    take_hit = 1'b0;
    rd_done  = 1'b0;
    case (state)
      IDLE:
        if (wr_pend) begin
          start_wr = 1'b1;
          state_n  = WR;
        end else if (rd_pend && hit) begin
          take_hit = 1'b1;
        end else if (rd_pend && drain_cnt == 7'd0) begin
          start_rd = 1'b1;
          state_n  = RD_CMD;
        end
      WR:      state_n = DDRAM_BUSY ? WR : IDLE;
      RD_CMD:  state_n = DDRAM_BUSY ? RD_CMD : RD_WAIT;
      RD_WAIT: begin
        rd_done = DDRAM_DOUT_READY;
        state_n = DDRAM_DOUT_READY ? IDLE : RD_WAIT;
      end
      default: state_n = IDLE;
    endcase
  end
  // DDRAM command/data registers, acknowledge toggles and the stale-beat drain counter
  always_ff @(posedge DDRAM_CLK)
    if (!RESET_N) begin
      we_ack     <= 1'b0;
      rd_ack     <= 1'b0;
      dout       <= '0;
      DDRAM_RD   <= 1'b0;
      DDRAM_WE   <= 1'b0;
      DDRAM_ADDR <= '0;
      DDRAM_DIN  <= '0;
      DDRAM_BE   <= '0;
      drain_cnt  <= 7'(DRAIN_CYCLES);
    end else begin
      if (start_wr) begin
        DDRAM_ADDR <= BASE_ADDR + 29'(wraddr[AW-1:3]);
        DDRAM_DIN  <= {4{din}};
        DDRAM_BE   <= hw_be(wraddr[2:1]);
        DDRAM_WE   <= 1'b1;
      end
      if (start_rd) begin
        DDRAM_ADDR <= BASE_ADDR + 29'(rdaddr[AW-1:3]);
        DDRAM_RD   <= 1'b1;
      end
      if (state == WR && !DDRAM_BUSY) begin
        DDRAM_WE <= 1'b0;
        we_ack   <= ~we_ack;
      end
      if (state == RD_CMD && !DDRAM_BUSY) DDRAM_RD <= 1'b0;
      if (take_hit || rd_done) begin
        dout   <= take_hit ? line_data : DDRAM_DOUT;
        rd_ack <= ~rd_ack;
      end
      drain_cnt <= (DDRAM_DOUT_READY || drain_cnt == 7'd0) ? 7'd0 : drain_cnt - 7'd1;
    end
endmodule

// File: tb/tb_ddram_rom_bridge.sv
// tb_ddram_rom_bridge: directed bench with a DDRAM memory model, a requester-side golden image and per-cycle checks
module tb_ddram_rom_bridge;
  localparam logic [28:0] BASE = 29'h06000000;
  localparam int          LAT  = 7;
`ifdef DDRAM_ROM_RDCACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        RESET_N = 1'b0;
  logic [24:0] wraddr = '0, rdaddr = '0;
  logic [15:0] din = '0;
  logic        we_req = 1'b0, rd_req = 1'b0;
  logic        we_ack, rd_ack;
  logic [63:0] dout;
  logic        busy = 1'b0;
  logic [7:0]  burstcnt, be;
  logic [28:0] addr;
  logic [63:0] ddr_dout = '0;
  logic        ddr_ready = 1'b0;
  logic        ddr_rd, ddr_we;
  logic [63:0] ddr_din;

  always #5 clk = ~clk;

  ddram_rom_bridge dut (
    .DDRAM_CLK        (clk),
    .RESET_N          (RESET_N),
    .wraddr           (wraddr),
    .din              (din),
    .we_req           (we_req),
    .we_ack           (we_ack),
    .rdaddr           (rdaddr),
    .rd_req           (rd_req),
    .rd_ack           (rd_ack),
    .dout             (dout),
    .DDRAM_BUSY       (busy),
    .DDRAM_BURSTCNT   (burstcnt),
    .DDRAM_ADDR       (addr),
    .DDRAM_DOUT       (ddr_dout),
    .DDRAM_DOUT_READY (ddr_ready),
    .DDRAM_RD         (ddr_rd),
    .DDRAM_DIN        (ddr_din),
    .DDRAM_BE         (be),
    .DDRAM_WE         (ddr_we)
  );

  int          n_chk = 0, n_fail = 0;
  int          cyc = 0, rst_edges = 0;
  logic [63:0] mem  [logic [28:0]];
  logic [63:0] gold [logic [28:0]];
  logic [28:0] rd_q [$];
  int          due_q[$];
  logic [28:0] exp_wa = '0, exp_ra = '0, last_we_addr = '0, last_rd_addr = '0;
  logic [63:0] exp_wdin = '0, exp_dout = '0, last_we_din = '0, mw;
  logic [7:0]  exp_wbe = '0, last_we_be = '0;
  int          we_hi = 0, we_acc = 0, rd_acc = 0, first_we = -1, first_rd = -1;

  function automatic logic [63:0] pat(input logic [28:0] a);
    return {a, 6'h2A, a};
  endfunction
  function automatic logic [63:0] mem_rd(input logic [28:0] a);
    return mem.exists(a) ? mem[a] : pat(a);
  endfunction
  function automatic logic [63:0] gold_rd(input logic [28:0] a);
    return gold.exists(a) ? gold[a] : pat(a);
  endfunction
  function automatic logic [7:0] lane_be(input logic [1:0] k);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = (i / 2 == int'(k));
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic bad(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: no response within cycle budget", name);
  endtask

  // cycle count, reset tracking and DDRAM read responder (fixed latency, one beat per command)
  always @(posedge clk) begin
    cyc++;
    rst_edges = RESET_N ? 0 : rst_edges + 1;
    #1;
    ddr_ready = 1'b0;
    if (rd_q.size() != 0 && cyc >= due_q[0]) begin
      ddr_dout  = mem_rd(rd_q.pop_front());
      ddr_ready = 1'b1;
      void'(due_q.pop_front());
    end
  end

  // per-cycle compare against the model; also accepts DDRAM commands into the memory model
  always @(negedge clk) begin
    if (rst_edges > 0) begin
      chk("rst_we_ack",   64'(we_ack),   64'd0);
      chk("rst_rd_ack",   64'(rd_ack),   64'd0);
      chk("rst_dout",     dout,          64'd0);
      chk("rst_rd",       64'(ddr_rd),   64'd0);
      chk("rst_we",       64'(ddr_we),   64'd0);
      chk("rst_addr",     64'(addr),     64'd0);
      chk("rst_din",      ddr_din,       64'd0);
      chk("rst_be",       64'(be),       64'd0);
      chk("rst_burstcnt", 64'(burstcnt), 64'd1);
    end else if (RESET_N) begin
      chk("burstcnt", 64'(burstcnt), 64'd1);
      chk("rd_we_exclusive", 64'(ddr_rd & ddr_we), 64'd0);
      if (ddr_we) begin
        chk("we_addr", 64'(addr), 64'(exp_wa));
        chk("we_din",  ddr_din,   exp_wdin);
        chk("we_be",   64'(be),   64'(exp_wbe));
        we_hi++;
      end
      if (ddr_rd) chk("rd_addr", 64'(addr), 64'(exp_ra));
      if (ddr_rd || ddr_we) chk("one_outstanding", 64'(rd_q.size()), 64'd0);
      if (rd_ack == rd_req) chk("dout", dout, exp_dout);
      if (ddr_we && !busy) begin
        mw = mem_rd(addr);
        for (int i = 0; i < 8; i++) if (be[i]) mw[8*i +: 8] = ddr_din[8*i +: 8];
        mem[addr] = mw;
        last_we_addr = addr;
        last_we_din  = ddr_din;
        last_we_be   = be;
        we_acc++;
        if (first_we < 0) first_we = cyc;
      end
      if (ddr_rd && !busy) begin
        rd_q.push_back(addr);
        due_q.push_back(cyc + LAT);
        last_rd_addr = addr;
        rd_acc++;
        if (first_rd < 0) first_rd = cyc;
      end
    end
  end

  task automatic prep_write(input logic [24:0] a, input logic [15:0] d);
    logic [63:0] g;
    exp_wa   = BASE + 29'(a[24:3]);
    exp_wdin = {4{d}};
    exp_wbe  = lane_be(a[2:1]);
    g = gold_rd(exp_wa);
    g[16 * int'(a[2:1]) +: 16] = d;
    gold[exp_wa] = g;
    wraddr = a;
    din    = d;
  endtask
  task automatic prep_read(input logic [24:0] a);
    exp_ra   = BASE + 29'(a[24:3]);
    exp_dout = gold_rd(exp_ra);
    rdaddr   = a;
  endtask

  task automatic do_write(input logic [24:0] a, input logic [15:0] d, input int nbusy, output int edges);
    prep_write(a, d);
    we_hi  = 0;
    we_acc = 0;
    edges  = 0;
    busy   = 1'b0;
    we_req = ~we_req;
    while (we_ack != we_req && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
      busy = edges <= nbusy;
    end
    busy = 1'b0;
    if (we_ack != we_req) bad("wr_ack_timeout");
  endtask

  task automatic do_read(input logic [24:0] a, output int edges, output int rds);
    prep_read(a);
    rd_acc = 0;
    edges  = 0;
    rd_req = ~rd_req;
    while (rd_ack != rd_req && edges < 300) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (rd_ack != rd_req) bad("rd_ack_timeout");
    rds = rd_acc;
  endtask

  initial begin
    int e, rds, we_e, rd_e;
    mem[29'h06000020]  = 64'h0123456789ABCDEF;
    gold[29'h06000020] = 64'h0123456789ABCDEF;
    repeat (3) @(posedge clk);
    #1 RESET_N = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    do_write(25'h000006, 16'hA55A, 0, e);
    chk("wr_ack_edges", 64'(e), 64'd2);
    chk("we_pulse_cycles", 64'(we_hi), 64'd1);
    chk("we_accepts", 64'(we_acc), 64'd1);
    chk("we_addr_lit", 64'(last_we_addr), 64'(29'h06000000));
    chk("we_be_lit", 64'(last_we_be), 64'h00000000000000C0);
    chk("we_din_lit", last_we_din, 64'hA55AA55AA55AA55A);
    do_write(25'h000006, 16'hA55A, 5, e);
    chk("busy_ack_edges", 64'(e), 64'd7);
    chk("busy_we_cycles", 64'(we_hi), 64'd6);
    chk("busy_accepts", 64'(we_acc), 64'd1);
    do_read(25'h000100, e, rds);
    chk("miss_edges", 64'(e), 64'(2 + LAT));
    chk("miss_rd_cmds", 64'(rds), 64'd1);
    chk("miss_addr_lit", 64'(last_rd_addr), 64'(29'h06000020));
    chk("miss_dout_lit", dout, 64'h0123456789ABCDEF);
    do_read(25'h000100, e, rds);
    chk("reread_edges", 64'(e), CACHE ? 64'd1 : 64'(2 + LAT));
    chk("reread_rd_cmds", 64'(rds), CACHE ? 64'd0 : 64'd1);
    chk("reread_dout_lit", dout, 64'h0123456789ABCDEF);
    do_write(25'h000102, 16'h1234, 0, e);
    chk("inval_wr_edges", 64'(e), 64'd2);
    do_read(25'h000100, e, rds);
    chk("inval_rd_cmds", 64'(rds), 64'd1);
    chk("inval_edges", 64'(e), 64'(2 + LAT));
    chk("inval_dout_lit", dout, 64'h012345671234CDEF);
    prep_write(25'h000208, 16'hBEEF);
    prep_read(25'h000300);
    first_we = -1;
    first_rd = -1;
    we_e = 0;
    rd_e = 0;
    e = 0;
    we_req = ~we_req;
    rd_req = ~rd_req;
    while ((we_ack != we_req || rd_ack != rd_req) && e < 300) begin
      @(posedge clk);
      #1;
      e++;
      if (we_e == 0 && we_ack == we_req) we_e = e;
      if (rd_e == 0 && rd_ack == rd_req) rd_e = e;
    end
    if (we_ack != we_req || rd_ack != rd_req) bad("simul_timeout");
    chk("simul_we_ack_edge", 64'(we_e), 64'd2);
    chk("simul_rd_ack_edge", 64'(rd_e), 64'(4 + LAT));
    chk("simul_we_before_rd", 64'(first_we >= 0 && first_we < first_rd), 64'd1);
    do_read(25'h000208, e, rds);
    chk("merge_rd_cmds", 64'(rds), 64'd1);
    chk("merge_dout", dout, gold_rd(29'h06000041));
    prep_read(25'h000400);
    rd_req = ~rd_req;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("inflight_before_reset", 64'(rd_q.size()), 64'd1);
    RESET_N  = 1'b0;
    rd_req   = 1'b0;
    we_req   = 1'b0;
    exp_dout = '0;
    repeat (3) @(posedge clk);
    #1 RESET_N = 1'b1;
    e = 0;
    while (rd_q.size() != 0 && e < 50) begin
      @(posedge clk);
      #1;
      e++;
    end
    if (rd_q.size() != 0) bad("stale_beat_timeout");
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("stale_dout", dout, 64'd0);
    chk("stale_rd_ack", 64'(rd_ack), 64'd0);
    do_read(25'h000500, e, rds);
    chk("post_reset_edges", 64'(e), 64'(2 + LAT));
    chk("post_reset_rd_cmds", 64'(rds), 64'd1);
    chk("post_reset_dout", dout, pat(29'h060000A0));
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end
endmodule
